// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared definitions for the instruction-memory boot loader.
//   state_t    : loader FSM state encoding (3-bit).
//   WORD_BYTES : bytes per instruction word (4).
//   LEN_W      : width of the stream word-count field (16).
//   IDX_W      : width of the byte index inside a word.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (CHK state is only reachable
// when it is defined; the encoding is always present).
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN0  = 3'd0,
    LEN1  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 16;
  localparam int IDX_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte stream and instruction-memory write bus of the loader.
//   in_data/in_valid/in_ready : byte stream, valid/ready handshake.
//   imem_we/imem_addr/imem_wdata : one-cycle word write into instruction memory.
// modport master : the loader (accepts bytes, drives the memory write).
// modport slave  : the environment (byte source and memory).
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic [7:0]              in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    imem_we;
  logic [ADDR_W-1:0]       imem_addr;
  logic [8*WORD_BYTES-1:0] imem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_asm.sv
// imem_loader_asm -- byte-to-word assembler.
//   clk, rst : clock, asynchronous active-low reset.
//   clr      : synchronous clear of byte index and word register.
//   en       : a byte is accepted this cycle; din goes into the current lane.
//   word     : assembled little-endian word (byte 0 in bits 7:0).
//   last     : the current lane is the final byte of the word.
module imem_loader_asm
  import imem_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [7:0]              din,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    last
);

  logic [IDX_W-1:0] idx_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg <= '0;
    end else if (clr) begin
      idx_reg <= '0;
    end else if (en) begin
      // wraps naturally to lane 0 after the last byte of a word
      idx_reg <= idx_reg + 1'b1;
    end
  end

  // One register per byte lane; a lane only loads when the index selects it,
  // so the word stays stable while the top module writes it out.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lane_reg <= '0;
        end else if (clr) begin
          lane_reg <= '0;
        end else if (en && (idx_reg == IDX_W'(gi))) begin
          lane_reg <= din;
        end
      end
      assign word[8*gi +: 8] = lane_reg;
    end
  endgenerate

  assign last = (idx_reg == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- boot-time writer for the MIPS instruction memory.
// Stream: 2-byte little-endian word count N, then N little-endian words.
// Words are written to consecutive addresses from BASE_ADDR (wrapping modulo
// 2**ADDR_W); the core is held in reset until the image is loaded.
//   clk, rst   : clock, asynchronous active-low reset.
//   start      : re-arm pulse, honoured only in DONE or ERR.
//   bus        : imem_loader_if.master (byte stream + memory write port).
//   cpu_rst    : active-high reset to the core, released on successful load.
//   done, err  : load finished / aborted (levels).
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- a trailing byte equal to
// the XOR of all preceding stream bytes must follow the last word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  imem_loader_if.master        bus,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned       DEPTH = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_t                  state_reg;
  logic                    in_ready_reg;
  logic                    we_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [LEN_W-1:0]        len_reg;
  logic [LEN_W-1:0]        cnt_reg;
  logic                    cpu_rst_reg;
  logic                    done_reg;
  logic                    err_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]              xor_reg;
`endif

  logic                    accept;
  logic                    restart;
  logic [LEN_W-1:0]        len_full;
  logic                    too_long;
  logic [LEN_W-1:0]        cnt_next;
  logic [8*WORD_BYTES-1:0] asm_word;
  logic                    asm_last;

  assign accept   = bus.in_valid & in_ready_reg;
  assign restart  = start && ((state_reg == DONE) || (state_reg == ERR));
  // full count as it will be once the high byte in LEN1 is latched
  assign len_full = {bus.in_data, len_reg[7:0]};
  assign too_long = 32'(len_full) > DEPTH;
  assign cnt_next = cnt_reg + 1'b1;

  imem_loader_asm u_asm (
    .clk  (clk),
    .rst  (rst),
    .clr  (restart),
    .en   (accept && (state_reg == DATA)),
    .din  (bus.in_data),
    .word (asm_word),
    .last (asm_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= LEN0;
      in_ready_reg <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= BASE;
      len_reg      <= '0;
      cnt_reg      <= '0;
      cpu_rst_reg  <= 1'b1;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_reg      <= '0;
`endif
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        LEN0: begin
          in_ready_reg <= 1'b1;
          if (accept) begin
            len_reg[7:0] <= bus.in_data;
            state_reg    <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            len_reg[15:8] <= bus.in_data;
            if (len_full == '0) begin
              state_reg    <= DONE;
              in_ready_reg <= 1'b0;
              done_reg     <= 1'b1;
              cpu_rst_reg  <= 1'b0;
            end else if (too_long) begin
              state_reg    <= ERR;
              in_ready_reg <= 1'b0;
              err_reg      <= 1'b1;
            end else begin
              state_reg    <= DATA;
            end
          end
        end
        DATA: begin
          // the assembler latches this byte on the same edge
          if (accept && asm_last) begin
            state_reg    <= WRITE;
            in_ready_reg <= 1'b0;
            we_reg       <= 1'b1;
          end
        end
        WRITE: begin
          cnt_reg <= cnt_next;
          if (cnt_next == len_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_reg    <= CHK;
            in_ready_reg <= 1'b1;
`else
            state_reg    <= DONE;
            done_reg     <= 1'b1;
            cpu_rst_reg  <= 1'b0;
`endif
          end else begin
            state_reg    <= DATA;
            in_ready_reg <= 1'b1;
            addr_reg     <= addr_reg + 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            in_ready_reg <= 1'b0;
            if (bus.in_data == xor_reg) begin
              state_reg   <= DONE;
              done_reg    <= 1'b1;
              cpu_rst_reg <= 1'b0;
            end else begin
              state_reg   <= ERR;
              err_reg     <= 1'b1;
            end
          end
        end
`endif
        DONE, ERR: begin
          if (start) begin
            state_reg    <= LEN0;
            in_ready_reg <= 1'b1;
            addr_reg     <= BASE;
            len_reg      <= '0;
            cnt_reg      <= '0;
            cpu_rst_reg  <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
          end
        end
        default: begin
          // unreachable encodings: park safely with the core held in reset
          state_reg    <= ERR;
          in_ready_reg <= 1'b0;
          cpu_rst_reg  <= 1'b1;
          done_reg     <= 1'b0;
          err_reg      <= 1'b1;
        end
      endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (restart) begin
        xor_reg <= '0;
      end else if (accept && (state_reg != CHK)) begin
        xor_reg <= xor_reg ^ bus.in_data;
      end
`endif
    end
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.imem_we    = we_reg;
  assign bus.imem_addr  = addr_reg;
  assign bus.imem_wdata = asm_word;
  assign cpu_rst        = cpu_rst_reg;
  assign done           = done_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- directed bench for imem_loader.
// Two loaders (BASE_ADDR 0 and 4, ADDR_W 8) receive the same byte stream in
// lockstep; a negedge monitor logs every write strobe of each.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       cpu_rst0, done0, err0;
  logic       cpu_rst4, done4, err4;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8)) if0 ();
  imem_loader_if #(.ADDR_W(8)) if4 ();

  assign if0.in_data  = in_data;
  assign if0.in_valid = in_valid;
  assign if4.in_data  = in_data;
  assign if4.in_valid = in_valid;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .bus(if0),
    .cpu_rst(cpu_rst0), .done(done0), .err(err0)
  );

  imem_loader #(.ADDR_W(8), .BASE_ADDR(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .bus(if4),
    .cpu_rst(cpu_rst4), .done(done4), .err(err4)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] tb_xor = 8'h00;
  bit   mon_en = 1'b0;

  logic [7:0]  wr0_addr [1024];
  logic [31:0] wr0_data [1024];
  logic [7:0]  wr4_addr [1024];
  logic [31:0] wr4_data [1024];
  int wr0_cnt = 0;
  int wr4_cnt = 0;
  int viol = 0;
  int last_we_cycle = 0;
  int done_cycle = 0;
  bit done_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      if (if0.imem_we) begin
        if (wr0_cnt < 1024) begin
          wr0_addr[wr0_cnt] = if0.imem_addr;
          wr0_data[wr0_cnt] = if0.imem_wdata;
        end
        wr0_cnt++;
        last_we_cycle = cyc;
      end
      if (if4.imem_we) begin
        if (wr4_cnt < 1024) begin
          wr4_addr[wr4_cnt] = if4.imem_addr;
          wr4_data[wr4_cnt] = if4.imem_wdata;
        end
        wr4_cnt++;
      end
      // while loading, in_ready must be low exactly in the write cycles
      if (mon_en && ((if0.imem_we && if0.in_ready) ||
                     (!if0.imem_we && !if0.in_ready && !done0 && !err0)))
        viol++;
      if (done0 && !done_prev) done_cycle = cyc;
      done_prev = done0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!if0.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 32'(guard), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    tb_xor   = tb_xor ^ b;
  endtask

  task automatic send_basic(input bit gaps);
    logic [7:0] img [10];
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h04, 8'h00, 8'h01, 8'hAC};
    for (int i = 0; i < 10; i++) send_byte(img[i], gaps);
    if (CHK_ON) send_byte(tb_xor, gaps);
  endtask

  task automatic wait_end(input string tag);
    int g = 0;
    while (!(done0 || err0) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_wait"}, 32'(g < 2000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // start pulse with a simultaneous byte that must not be accepted
  task automatic restart();
    start    = 1'b1;
    in_data  = 8'h55;
    in_valid = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    tb_xor   = 8'h00;
  endtask

  task automatic check_basic(input string tag, input int b0, input int b4);
    check({tag, "_n0"},    32'(wr0_cnt - b0), 32'd2);
    check({tag, "_a0_0"},  32'(wr0_addr[b0]), 32'd0);
    check({tag, "_d0_0"},  wr0_data[b0], 32'h20000013);
    check({tag, "_a0_1"},  32'(wr0_addr[b0+1]), 32'd1);
    check({tag, "_d0_1"},  wr0_data[b0+1], 32'hAC010004);
    check({tag, "_n4"},    32'(wr4_cnt - b4), 32'd2);
    check({tag, "_a4_0"},  32'(wr4_addr[b4]), 32'd4);
    check({tag, "_a4_1"},  32'(wr4_addr[b4+1]), 32'd5);
    check({tag, "_d4_1"},  wr4_data[b4+1], 32'hAC010004);
    check({tag, "_done"},  32'(done0), 32'd1);
    check({tag, "_cpurst"}, 32'(cpu_rst0), 32'd0);
    check({tag, "_err"},   32'(err0), 32'd0);
  endtask

  initial begin
    int b0, b4, bad;
    logic [31:0] w;

    // ---- reset hold ----
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(if0.in_ready), 32'd0);
    check("rst_addr4",    32'(if4.imem_addr), 32'd4);
    check("rst_wdata",    if0.imem_wdata, 32'd0);
    check("rst_cpu_rst",  32'(cpu_rst0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(if0.in_ready), 32'd1);
    check("rel_cpu_rst",  32'(cpu_rst0), 32'd1);
    check("rel_done",     32'(done0), 32'd0);
    check("rel_err",      32'(err0), 32'd0);
    repeat (3) @(negedge clk);
    check("rel_no_we",    32'(wr0_cnt), 32'd0);
    mon_en = 1'b1;

    // ---- basic load ----
    b0 = wr0_cnt; b4 = wr4_cnt;
    send_basic(1'b0);
    wait_end("basic");
    check_basic("basic", b0, b4);
    if (!CHK_ON) check("basic_done_lat", 32'(done_cycle - last_we_cycle), 32'd1);

    // ---- restart from DONE ----
    restart();
    check("rs_cpu_rst",  32'(cpu_rst0), 32'd1);
    check("rs_done",     32'(done0), 32'd0);
    check("rs_in_ready", 32'(if0.in_ready), 32'd1);

    // ---- same image with gaps ----
    b0 = wr0_cnt; b4 = wr4_cnt;
    send_basic(1'b1);
    wait_end("gaps");
    check_basic("gaps", b0, b4);
    check("gaps_ready_viol", 32'(viol), 32'd0);

    // ---- N = 0 ----
    restart();
    b0 = wr0_cnt;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end("n0");
    check("n0_done",   32'(done0), 32'd1);
    check("n0_cpurst", 32'(cpu_rst0), 32'd0);
    check("n0_writes", 32'(wr0_cnt - b0), 32'd0);

    // ---- N = DEPTH + 1 ----
    restart();
    b0 = wr0_cnt;
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    wait_end("nbig");
    check("nbig_err",    32'(err0), 32'd1);
    check("nbig_cpurst", 32'(cpu_rst0), 32'd1);
    check("nbig_done",   32'(done0), 32'd0);
    check("nbig_writes", 32'(wr0_cnt - b0), 32'd0);
    restart();
    check("rs_err_cleared", 32'(err0), 32'd0);
    check("rs_err_cpurst",  32'(cpu_rst0), 32'd1);

    // ---- N = DEPTH, wraps on the BASE_ADDR 4 instance ----
    b0 = wr0_cnt; b4 = wr4_cnt;
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int k = 0; k < 256; k++) begin
      w = 32'hC0DE0000 | 32'(k);
      for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b0);
    end
    if (CHK_ON) send_byte(tb_xor, 1'b0);
    wait_end("full");
    check("full_n4",      32'(wr4_cnt - b4), 32'd256);
    check("full_last_a4", 32'(wr4_addr[b4+255]), 32'd3);
    check("full_first_a4", 32'(wr4_addr[b4]), 32'd4);
    check("full_last_a0", 32'(wr0_addr[b0+255]), 32'd255);
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (wr0_data[b0+k] !== (32'hC0DE0000 | 32'(k))) bad++;
      if (wr4_addr[b4+k] !== 8'(k + 4)) bad++;
    end
    check("full_words", 32'(bad), 32'd0);
    check("full_done",  32'(done0), 32'd1);

    // ---- reset mid-load ----
    restart();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_cpu_rst",  32'(cpu_rst0), 32'd1);
    check("mid_in_ready", 32'(if0.in_ready), 32'd0);
    check("mid_we",       32'(if0.imem_we), 32'd0);
    check("mid_addr4",    32'(if4.imem_addr), 32'd4);
    check("mid_wdata",    if0.imem_wdata, 32'd0);
    check("mid_done",     32'(done0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tb_xor = 8'h00;
    @(negedge clk);
    mon_en = 1'b1;
    b0 = wr0_cnt; b4 = wr4_cnt;
    send_basic(1'b0);
    wait_end("replay");
    check_basic("replay", b0, b4);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // ---- checksum trailer good / bad ----
    restart();
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    send_byte(8'h45, 1'b0);
    wait_end("ck_good");
    check("ck_good_done", 32'(done0), 32'd1);
    check("ck_good_err",  32'(err0), 32'd0);
    check("ck_good_word", if0.imem_wdata, 32'h44332211);
    restart();
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end("ck_bad");
    check("ck_bad_err",    32'(err0), 32'd1);
    check("ck_bad_cpurst", 32'(cpu_rst0), 32'd1);
`endif

    check("final_ready_viol", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
